// File: rtl/pipe_stage_buf.sv
// Two-entry (main + skid) valid/ready pipeline buffer with flush, freeze and exception encoding.
// Define PIPE_STAGE_PERF_EN to add the backpressure and flush performance counters.
module pipe_stage_buf #(
    parameter int DATA_W = 64,
    parameter int EXC_W  = 12,
    parameter int CODE_W = $clog2(EXC_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic [EXC_W-1:0]  i_exc,
    input  logic              i_flush,
    input  logic              i_stall,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [EXC_W-1:0]  o_exc,
    output logic              o_exc_any,
    output logic [CODE_W-1:0] o_exc_code
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       o_bp_cnt,
    output logic [15:0]       o_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    occ_e              state_q, state_d;
    logic [DATA_W-1:0] main_data_q, skid_data_q;
    logic [EXC_W-1:0]  main_exc_q, skid_exc_q;
    logic              main_vld;
    logic              accept;
    logic              pop;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;
    logic [CODE_W-1:0] exc_code;

    // Ready comes only from registered occupancy and the freeze input, never from i_ready.
    assign main_vld = (state_q != EMPTY);
    assign o_valid  = main_vld;
    assign o_ready  = (state_q != FULL) & ~i_stall;
    assign accept   = i_valid & o_ready & ~i_flush;
    assign pop      = main_vld & i_ready & ~i_stall & ~i_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (i_flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d      = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        state_d   = FULL;
                        load_skid = 1'b1;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d        = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Flush only drops the valids; payload registers keep their contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_data_q <= '0;
            main_exc_q  <= '0;
            skid_data_q <= '0;
            skid_exc_q  <= '0;
        end else begin
            if (load_main_in) begin
                main_data_q <= i_data;
                main_exc_q  <= i_exc;
            end else if (load_main_skid) begin
                main_data_q <= skid_data_q;
                main_exc_q  <= skid_exc_q;
            end
            if (load_skid) begin
                skid_data_q <= i_data;
                skid_exc_q  <= i_exc;
            end
        end
    end

    assign o_data = main_data_q;

    genvar gi;
    generate
        for (gi = 0; gi < EXC_W; gi++) begin : g_exc_mask
            assign o_exc[gi] = main_exc_q[gi] & main_vld;
        end
    endgenerate

    // Ascending scan so the highest set bit is the last one written.
    always_comb begin
        exc_code = '0;
        for (int i = 0; i < EXC_W; i++) begin
            if (o_exc[i]) begin
                exc_code = i[CODE_W-1:0];
            end
        end
    end

    assign o_exc_any  = |o_exc;
    assign o_exc_code = exc_code;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] bp_cnt_q;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bp_cnt_q    <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((main_vld & ~i_ready) | i_stall) begin
                bp_cnt_q <= bp_cnt_q + 32'd1;
            end
            if (i_flush && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign o_bp_cnt    = bp_cnt_q;
    assign o_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: directed vector table, async reset sequence, then random traffic vs a queue model.
module tb_pipe_stage_buf;

    localparam int DATA_W = 64;
    localparam int EXC_W  = 12;
    localparam int CODE_W = $clog2(EXC_W);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_valid = 1'b0;
    logic              o_ready;
    logic [DATA_W-1:0] i_data = '0;
    logic [EXC_W-1:0]  i_exc = '0;
    logic              i_flush = 1'b0;
    logic              i_stall = 1'b0;
    logic              o_valid;
    logic              i_ready = 1'b0;
    logic [DATA_W-1:0] o_data;
    logic [EXC_W-1:0]  o_exc;
    logic              o_exc_any;
    logic [CODE_W-1:0] o_exc_code;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]       o_bp_cnt;
    logic [15:0]       o_flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_buf #(.DATA_W(DATA_W), .EXC_W(EXC_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_data     (i_data),
        .i_exc      (i_exc),
        .i_flush    (i_flush),
        .i_stall    (i_stall),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_exc      (o_exc),
        .o_exc_any  (o_exc_any),
        .o_exc_code (o_exc_code)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .o_bp_cnt   (o_bp_cnt),
        .o_flush_cnt(o_flush_cnt)
`endif
    );

    typedef struct {
        logic              v;
        logic              rdy;
        logic              stall;
        logic              flush;
        logic [DATA_W-1:0] data;
        logic [EXC_W-1:0]  exc;
        logic              e_ov;
        logic              e_ordy;
        logic [DATA_W-1:0] e_od;
        logic [EXC_W-1:0]  e_oexc;
        int                e_code;
    } vec_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [EXC_W-1:0]  exc;
    } beat_t;

    vec_t  vecs[21];
    beat_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic int top_bit(input logic [EXC_W-1:0] e);
        for (int i = EXC_W - 1; i >= 0; i--) begin
            if (e[i]) return i;
        end
        return 0;
    endfunction

    initial begin
        logic              exp_v, exp_rdy, do_pop, do_acc;
        logic [DATA_W-1:0] last_front;
        logic [EXC_W-1:0]  exp_exc;
        beat_t             b;
`ifdef PIPE_STAGE_PERF_EN
        logic [31:0]       bp_m;
        logic [15:0]       fl_m;
`endif

        //            v  rdy st fl data      exc      ov ordy od        oexc     code
        vecs[0]  = '{1, 1, 0, 0, 64'h11,  12'h000, 0, 1, 64'h0,    12'h000, 0};
        vecs[1]  = '{0, 1, 0, 0, 64'h0,   12'h000, 1, 1, 64'h11,   12'h000, 0};
        vecs[2]  = '{1, 0, 0, 0, 64'hA,   12'h000, 0, 1, 64'h11,   12'h000, 0};
        vecs[3]  = '{1, 0, 0, 0, 64'hB,   12'h000, 1, 1, 64'hA,    12'h000, 0};
        vecs[4]  = '{1, 0, 0, 0, 64'hD,   12'h000, 1, 0, 64'hA,    12'h000, 0};
        vecs[5]  = '{0, 1, 0, 0, 64'h0,   12'h000, 1, 0, 64'hA,    12'h000, 0};
        vecs[6]  = '{0, 1, 0, 0, 64'h0,   12'h000, 1, 1, 64'hB,    12'h000, 0};
        vecs[7]  = '{0, 0, 0, 0, 64'h0,   12'h000, 0, 1, 64'hB,    12'h000, 0};
        vecs[8]  = '{1, 0, 0, 0, 64'hA1,  12'h000, 0, 1, 64'hB,    12'h000, 0};
        vecs[9]  = '{1, 0, 0, 0, 64'hA2,  12'h000, 1, 1, 64'hA1,   12'h000, 0};
        vecs[10] = '{1, 1, 0, 1, 64'hC,   12'h000, 1, 0, 64'hA1,   12'h000, 0};
        vecs[11] = '{0, 1, 0, 0, 64'h0,   12'h000, 0, 1, 64'hA1,   12'h000, 0};
        vecs[12] = '{0, 1, 0, 0, 64'h0,   12'h000, 0, 1, 64'hA1,   12'h000, 0};
        vecs[13] = '{1, 0, 0, 0, 64'hE1,  12'h0A0, 0, 1, 64'hA1,   12'h000, 0};
        vecs[14] = '{1, 1, 0, 0, 64'hE2,  12'h800, 1, 1, 64'hE1,   12'h0A0, 7};
        vecs[15] = '{0, 0, 0, 0, 64'h0,   12'h000, 1, 1, 64'hE2,   12'h800, 11};
        vecs[16] = '{1, 1, 1, 0, 64'hF1,  12'h000, 1, 0, 64'hE2,   12'h800, 11};
        vecs[17] = '{1, 1, 1, 0, 64'hF1,  12'h000, 1, 0, 64'hE2,   12'h800, 11};
        vecs[18] = '{1, 1, 1, 0, 64'hF1,  12'h000, 1, 0, 64'hE2,   12'h800, 11};
        vecs[19] = '{0, 1, 0, 0, 64'h0,   12'h000, 1, 1, 64'hE2,   12'h800, 11};
        vecs[20] = '{0, 0, 0, 0, 64'h0,   12'h000, 0, 1, 64'hE2,   12'h000, 0};

        #12;
        rst = 1'b0;
        #1;
        chk("reset_o_valid", 64'(o_valid), 64'd0);
        chk("reset_o_data", o_data, 64'd0);
        chk("reset_o_exc", 64'(o_exc), 64'd0);
        chk("reset_o_exc_any", 64'(o_exc_any), 64'd0);
        chk("reset_o_exc_code", 64'(o_exc_code), 64'd0);
        chk("reset_o_ready", 64'(o_ready), 64'd1);
        @(posedge clk);
        #1;

        for (int n = 0; n < 21; n++) begin
            i_valid = vecs[n].v;
            i_ready = vecs[n].rdy;
            i_stall = vecs[n].stall;
            i_flush = vecs[n].flush;
            i_data  = vecs[n].data;
            i_exc   = vecs[n].exc;
            @(negedge clk);
            chk($sformatf("vec%0d_o_valid", n), 64'(o_valid), 64'(vecs[n].e_ov));
            chk($sformatf("vec%0d_o_ready", n), 64'(o_ready), 64'(vecs[n].e_ordy));
            chk($sformatf("vec%0d_o_data", n), o_data, vecs[n].e_od);
            chk($sformatf("vec%0d_o_exc", n), 64'(o_exc), 64'(vecs[n].e_oexc));
            chk($sformatf("vec%0d_o_exc_any", n), 64'(o_exc_any), 64'(vecs[n].e_oexc != 0));
            chk($sformatf("vec%0d_o_exc_code", n), 64'(o_exc_code), 64'(vecs[n].e_code));
            $display("vec %0d v=%0b rdy=%0b stall=%0b flush=%0b in=%0h -> ov=%0b ordy=%0b od=%0h code=%0d",
                     n, i_valid, i_ready, i_stall, i_flush, i_data, o_valid, o_ready, o_data, o_exc_code);
            @(posedge clk);
            #1;
        end

        // Fill to FULL, then hit reset between edges.
        i_valid = 1'b1; i_ready = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
        i_data = 64'h55; i_exc = '0;
        @(posedge clk);
        #1;
        i_data = 64'h66;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        chk("full_o_valid", 64'(o_valid), 64'd1);
        chk("full_o_ready", 64'(o_ready), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_o_valid", 64'(o_valid), 64'd0);
        chk("async_rst_o_ready", 64'(o_ready), 64'd1);
        chk("async_rst_o_data", o_data, 64'd0);
`ifdef PIPE_STAGE_PERF_EN
        chk("async_rst_bp_cnt", 64'(o_bp_cnt), 64'd0);
        chk("async_rst_flush_cnt", 64'(o_flush_cnt), 64'd0);
`endif
        $display("async reset mid-FULL: ov=%0b ordy=%0b od=%0h", o_valid, o_ready, o_data);
        @(posedge clk);
        #3;
        rst = 1'b0;

        q.delete();
        last_front = '0;
`ifdef PIPE_STAGE_PERF_EN
        bp_m = '0;
        fl_m = '0;
`endif
        for (int n = 0; n < 3000; n++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 2) != 0);
            i_stall = ($urandom_range(0, 9) == 0);
            i_flush = ($urandom_range(0, 24) == 0);
            i_data  = {$urandom, $urandom};
            i_exc   = ($urandom_range(0, 2) == 0) ? EXC_W'($urandom) : '0;
            @(negedge clk);
            exp_v   = (q.size() > 0);
            exp_rdy = (q.size() < 2) && !i_stall;
            exp_exc = exp_v ? q[0].exc : '0;
            chk("rnd_o_valid", 64'(o_valid), 64'(exp_v));
            chk("rnd_o_ready", 64'(o_ready), 64'(exp_rdy));
            chk("rnd_o_data", o_data, exp_v ? q[0].data : last_front);
            chk("rnd_o_exc", 64'(o_exc), 64'(exp_exc));
            chk("rnd_o_exc_any", 64'(o_exc_any), 64'(exp_exc != 0));
            chk("rnd_o_exc_code", 64'(o_exc_code), 64'(top_bit(exp_exc)));
`ifdef PIPE_STAGE_PERF_EN
            chk("rnd_bp_cnt", 64'(o_bp_cnt), 64'(bp_m));
            chk("rnd_flush_cnt", 64'(o_flush_cnt), 64'(fl_m));
            if ((exp_v && !i_ready) || i_stall) bp_m = bp_m + 1;
            if (i_flush && fl_m != 16'hFFFF) fl_m = fl_m + 1;
`endif
            $display("rnd %0d v=%0b rdy=%0b st=%0b fl=%0b in=%0h -> ov=%0b od=%0h occ=%0d",
                     n, i_valid, i_ready, i_stall, i_flush, i_data, o_valid, o_data, q.size());
            @(posedge clk);
            if (i_flush) begin
                q.delete();
            end else begin
                do_pop = exp_v && i_ready && !i_stall;
                do_acc = i_valid && exp_rdy;
                if (do_pop) void'(q.pop_front());
                if (do_acc) begin
                    b.data = i_data;
                    b.exc  = i_exc;
                    q.push_back(b);
                end
            end
            if (q.size() > 0) last_front = q[0].data;
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
